mux16_rr_scheduler: RTL

Round-robin scheduler that shares the team's 16:1 single-bit mux between 16 requesters. Each requester i owns mux input A[i]. The block picks one owner at a time, drives the 4-bit select, and returns a one-hot grant. Ownership lasts until the owner releases or a hold limit expires. It sits between the 16 requesting channels and the downstream single-bit consumer, and gives that consumer a fair, registered select.

---
 rtl/mux16_rr_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mux16_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux16_rr_scheduler
//
// Round-robin scheduler that shares one 16:1 single-bit mux among 16
// requesters. Exactly one channel owns the mux at a time. Ownership ends when
// the owner releases, drops its request, or has held the mux for HOLD_MAX
// cycles. On release the next requester is granted at the same edge, so there
// is no idle cycle between owners.
//
// Parameters:
//   HOLD_MAX   maximum consecutive cycles one owner may hold the mux (1..16)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req[15:0]  per-channel request; bit i asks for ownership of A[i]
//   rel        current owner gives up the mux after this cycle
//   A[15:0]    mux data inputs, A[i] driven by channel i
//   S[3:0]     registered select, index of the current (or last) owner
//   gnt[15:0]  registered one-hot grant, zero when there is no owner
//   gnt_valid  registered, high while an owner holds the mux
//   out        combinational A[S] while gnt_valid is high, else 0
// -----------------------------------------------------------------------------

// Plain 16:1 single-bit mux shared by the requesters.
module mux16 (
  input  logic [15:0] a_i,
  input  logic [3:0]  sel_i,
  output logic        y_o
);
  assign y_o = a_i[sel_i];
endmodule

module mux16_rr_scheduler #(
  parameter int HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        rel,
  input  logic [15:0] A,
  output logic [3:0]  S,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic        out
);

  localparam int            CW       = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    s_q, s_d;
  logic [3:0]    last_q, last_d;
  logic [15:0]   gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    base;
  logic [3:0]    pick;
  logic          any_req;
  logic          release_c;
  logic          mux_y;

  assign any_req = |req;

  // A releasing owner becomes the new 'last', so the search starts right
  // after the current owner; in IDLE it starts after the stored last owner.
  assign base = (state_q == OWN) ? s_q : last_q;

  // Round-robin search: scan from base+16 (= base itself) down to base+1 and
  // let the last hit win, which yields the first requester in the order
  // base+1, base+2, ..., base. The previous owner therefore comes last.
  always_comb begin
    pick = base;
    for (int j = 16; j >= 1; j--) begin
      if (req[base + 4'(j)]) pick = base + 4'(j);
    end
  end

  assign release_c = rel || !req[s_q] || (cnt_q == CNT_LAST);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = OWN;
          s_d     = pick;
          gnt_d   = 16'd1 << pick;
          cnt_d   = '0;
        end
      end

      OWN: begin
        if (release_c) begin
          last_d = s_q;
          if (any_req) begin
            // Back-to-back handoff, possibly to the same channel.
            s_d   = pick;
            gnt_d = 16'd1 << pick;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 4'd0;
      last_q  <= 4'd15;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  mux16 u_mux (
    .a_i   (A),
    .sel_i (s_q),
    .y_o   (mux_y)
  );

  assign S         = s_q;
  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == OWN);
  assign out       = gnt_valid & mux_y;

endmodule
